gpu_rect_engine: RTL and testbench
==================================

Name: gpu_rect_engine

Overview:
Second-generation 1-bpp framebuffer operation engine that executes rectangle fill, overlap-safe rectangle blit, and multi-bit horizontal pixel read/write commands. It adds raster ops (COPY/AND/OR/XOR) applied through read-modify-write. Framebuffer geometry and byte width are parameters. The engine sits between the command/CPU-side controller and the single-port pixel RAM. It drives one pixel address per cycle.

Parameters:
WIDTH, 320, framebuffer width in pixels
HEIGHT, 200, framebuffer height in pixels
XW, 9, x coordinate / width field bits (2**XW >= WIDTH)
YW, 8, y coordinate / height field bits (2**YW >= HEIGHT)
BYTE_BITS, 8, pixels per read/write-byte command

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  reset, asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high when IDLE; command accepted when cmd_valid&&cmd_ready at a clock edge
cmd_op  in  2  0 FILL, 1 BLIT, 2 READ_BYTE, 3 WRITE_BYTE
cmd_rop  in  2  0 COPY, 1 AND, 2 OR, 3 XOR (FILL/BLIT only)
cmd_x1, cmd_y1  in  XW, YW  source / fill / byte origin
cmd_x2, cmd_y2  in  XW, YW  blit destination origin
cmd_w, cmd_h  in  XW, YW  rectangle size (FILL/BLIT)
cmd_fill_value  in  1  fill pixel value
cmd_wr_byte  in  BYTE_BITS  WRITE_BYTE data; bit i goes to x1+i
mem_x, mem_y  out  XW, YW  pixel address
mem_rd_en  out  1  read strobe; mem_rd_data valid in the following cycle
mem_rd_data  in  1  read pixel
mem_wr_en, mem_wr_data  out  1, 1  write strobe / value
busy  out  1  ~cmd_ready
done  out  1  one-cycle pulse on command completion (including error completion)
error  out  1  last accepted command was rejected; held until next acceptance
rd_byte  out  BYTE_BITS  READ_BYTE result; bit i = pixel (x1+i, y1)
rd_byte_valid  out  1  one-cycle pulse, coincident with done for READ_BYTE

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. State is IDLE.
- Reset mid-command aborts immediately. The region may be partially written. No done pulse.
- All cmd_* fields are latched on acceptance. Changes to cmd_* while busy have no effect. cmd_valid while busy is ignored.
- Validation at acceptance uses XW+1 / YW+1 bit sums:
  - FILL/BLIT: error if w==0, h==0, x1+w>WIDTH or y1+h>HEIGHT.
  - BLIT only: also error if x2+w>WIDTH or y2+h>HEIGHT.
  - READ/WRITE_BYTE: error if x1+BYTE_BITS>WIDTH or y1>=HEIGHT.
  - On error: no memory strobe, done pulses in the next cycle, error=1.
  - Any accepted valid command clears error.
- mem_rd_en and mem_wr_en are never high in the same cycle. Both are 0 in IDLE.
- ROP f(s,d): COPY=s, AND=s&d, OR=s|d, XOR=s^d. For FILL, s = fill_value.
- Per-pixel cycle sequence (latency-1 RAM; data read at cycle n is sampled at end of cycle n+1):
  - FILL COPY: WR. 1 cycle/pixel.
  - FILL non-COPY: RD(dst), WR with mem_wr_data = f(fill, mem_rd_data). 2 cycles/pixel.
  - BLIT COPY: RD(src), WR with mem_wr_data = mem_rd_data. 2 cycles/pixel.
  - BLIT non-COPY: RD(src), RD(dst) capturing src, WR with f(src_captured, mem_rd_data). 3 cycles/pixel.
- Traversal:
  - FILL: row-major ascending, x fastest.
  - BLIT reverse mode is selected when (y2>y1) || (y2==y1 && x2>x1). Reverse mode iterates from (w-1,h-1) to (0,0) with x descending fastest. Otherwise iteration is ascending.
  - Overlapping blits must therefore produce a pure copy of the original source.
- READ_BYTE: mem_rd_en high in cycles 1..B (B=BYTE_BITS, acceptance edge ends cycle 0), with address (x1+i-1, y1) in cycle i. Bit i-1 is captured at the end of cycle i+1. rd_byte updates at the end of cycle B+1. rd_byte_valid and done are high in cycle B+2.
- WRITE_BYTE: mem_wr_en high in cycles 1..B with data cmd_wr_byte[i-1]. The ROP is ignored. done is high in cycle B+1.
- The done cycle is IDLE (cmd_ready=1), so a back-to-back command may be accepted in the done cycle.
- rd_byte holds its value until the next READ_BYTE completes.

Test Plan:
- FILL x1=5,y1=7,w=3,h=2,val=1,COPY -> wr_en cycles 1-6 at (5,7)(6,7)(7,7)(5,8)(6,8)(7,8), data 1; done cycle 7; error 0.
- Model RAM with row 0 = 0b1010 at x0..3; FILL x1=0,y1=0,w=4,h=1,val=1,XOR -> alternating rd/wr; final pixels 0,1,0,1; 8 busy cycles.
- BLIT src (0,0) to dst (1,0), w=4,h=1, src 1,0,1,1 -> reverse order writes x=4,3,2,1; final x1..4 = 1,0,1,1.
- WRITE_BYTE x1=312,y1=199,data 0xA5, then READ_BYTE same coordinates -> rd_byte=0xA5 with rd_byte_valid pulse in cycle 10 after read acceptance.
- FILL x1=318,w=3 (WIDTH=320) -> no strobes, done next cycle, error=1. Next valid FILL clears error at acceptance.
- Assert rst mid-BLIT -> all outputs 0 and cmd_ready=1 asynchronously. A new FILL is accepted right after deassertion.

Source files
------------

// File: rtl/gpu_rect_engine.sv
// gpu_rect_engine: 1-bpp framebuffer command engine.
// Executes rectangle FILL, overlap-safe BLIT and 8-pixel horizontal
// READ_BYTE / WRITE_BYTE against a single-port, read-latency-1 pixel RAM,
// issuing one pixel address per cycle. FILL/BLIT apply a raster op
// (COPY/AND/OR/XOR) through read-modify-write when it is not COPY.
module gpu_rect_engine #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 200,
  parameter int XW        = 9,
  parameter int YW        = 8,
  parameter int BYTE_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [1:0]           cmd_rop,
  input  logic [XW-1:0]        cmd_x1,
  input  logic [YW-1:0]        cmd_y1,
  input  logic [XW-1:0]        cmd_x2,
  input  logic [YW-1:0]        cmd_y2,
  input  logic [XW-1:0]        cmd_w,
  input  logic [YW-1:0]        cmd_h,
  input  logic                 cmd_fill_value,
  input  logic [BYTE_BITS-1:0] cmd_wr_byte,
  output logic [XW-1:0]        mem_x,
  output logic [YW-1:0]        mem_y,
  output logic                 mem_rd_en,
  input  logic                 mem_rd_data,
  output logic                 mem_wr_en,
  output logic                 mem_wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [BYTE_BITS-1:0] rd_byte,
  output logic                 rd_byte_valid
);

  localparam int BIW = (BYTE_BITS > 1) ? $clog2(BYTE_BITS) : 1;
  localparam logic [BIW-1:0] BI_LAST = BIW'(BYTE_BITS - 1);

  typedef enum logic [1:0] {
    OP_FILL     = 2'd0,
    OP_BLIT     = 2'd1,
    OP_RD_BYTE  = 2'd2,
    OP_WR_BYTE  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ROP_COPY = 2'd0,
    ROP_AND  = 2'd1,
    ROP_OR   = 2'd2,
    ROP_XOR  = 2'd3
  } rop_e;

  // S_RD_SRC/S_RD_DST/S_WR form the per-pixel micro-sequence for FILL/BLIT;
  // the byte states walk BYTE_BITS consecutive pixels on one row.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SRC,
    S_RD_DST,
    S_WR,
    S_BYTE_RD,
    S_BYTE_LAST,
    S_BYTE_WR
  } state_e;

  function automatic logic rop_f(rop_e rop, logic s, logic d);
    case (rop)
      ROP_AND: rop_f = s & d;
      ROP_OR:  rop_f = s | d;
      ROP_XOR: rop_f = s ^ d;
      default: rop_f = s;
    endcase
  endfunction

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  rop_e                 rop_q, rop_d;
  logic [XW-1:0]        x1_q, x1_d, x2_q, x2_d, w_q, w_d, cx_q, cx_d;
  logic [YW-1:0]        y1_q, y1_d, y2_q, y2_d, h_q, h_d, cy_q, cy_d;
  logic                 fill_q, fill_d;
  logic [BYTE_BITS-1:0] wr_byte_q, wr_byte_d;
  logic                 rev_q, rev_d;
  logic [BIW-1:0]       bi_q, bi_d;
  logic                 src_q, src_d;
  logic [BYTE_BITS-1:0] shift_q, shift_d;
  logic [BYTE_BITS-1:0] rd_byte_q, rd_byte_d;
  logic                 rd_byte_valid_q, rd_byte_valid_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  // Acceptance-time bounds checks use one extra bit so the sums cannot wrap.
  logic [XW:0] x1_end, x2_end, xb_end;
  logic [YW:0] y1_end, y2_end;
  logic        fill_bad, blit_bad, byte_bad, cmd_bad, cmd_rev;

  // Pixel addressing relative to the rectangle origin.
  logic [XW-1:0] src_x, dst_x, byte_x;
  logic [YW-1:0] src_y, dst_y;
  logic          last_px;

  // Combinational validation and address generation.
  always_comb begin
    x1_end   = {1'b0, cmd_x1} + {1'b0, cmd_w};
    x2_end   = {1'b0, cmd_x2} + {1'b0, cmd_w};
    xb_end   = {1'b0, cmd_x1} + (XW+1)'(BYTE_BITS);
    y1_end   = {1'b0, cmd_y1} + {1'b0, cmd_h};
    y2_end   = {1'b0, cmd_y2} + {1'b0, cmd_h};
    fill_bad = (cmd_w == '0) || (cmd_h == '0) ||
               (x1_end > (XW+1)'(WIDTH)) || (y1_end > (YW+1)'(HEIGHT));
    blit_bad = fill_bad ||
               (x2_end > (XW+1)'(WIDTH)) || (y2_end > (YW+1)'(HEIGHT));
    byte_bad = (xb_end > (XW+1)'(WIDTH)) ||
               ({1'b0, cmd_y1} >= (YW+1)'(HEIGHT));
    case (op_e'(cmd_op))
      OP_FILL: cmd_bad = fill_bad;
      OP_BLIT: cmd_bad = blit_bad;
      default: cmd_bad = byte_bad;
    endcase
    // Copying towards higher addresses must walk backwards so the source
    // is read before the overlapping destination overwrites it.
    cmd_rev  = (op_e'(cmd_op) == OP_BLIT) &&
               ((cmd_y2 > cmd_y1) || ((cmd_y2 == cmd_y1) && (cmd_x2 > cmd_x1)));

    src_x    = x1_q + cx_q;
    src_y    = y1_q + cy_q;
    dst_x    = (op_q == OP_BLIT) ? (x2_q + cx_q) : src_x;
    dst_y    = (op_q == OP_BLIT) ? (y2_q + cy_q) : src_y;
    byte_x   = x1_q + XW'(bi_q);
    last_px  = rev_q ? ((cx_q == '0) && (cy_q == '0))
                     : ((cx_q == w_q - XW'(1)) && (cy_q == h_q - YW'(1)));
  end

  // Next-state, datapath updates and memory strobes.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d         = state_q;
    op_d            = op_q;
    rop_d           = rop_q;
    x1_d            = x1_q;
    y1_d            = y1_q;
    x2_d            = x2_q;
    y2_d            = y2_q;
    w_d             = w_q;
    h_d             = h_q;
    fill_d          = fill_q;
    wr_byte_d       = wr_byte_q;
    rev_d           = rev_q;
    cx_d            = cx_q;
    cy_d            = cy_q;
    bi_d            = bi_q;
    src_d           = src_q;
    shift_d         = shift_q;
    rd_byte_d       = rd_byte_q;
    rd_byte_valid_d = 1'b0;
    done_d          = 1'b0;
    error_d         = error_q;
    mem_x           = '0;
    mem_y           = '0;
    mem_rd_en       = 1'b0;
    mem_wr_en       = 1'b0;
    mem_wr_data     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d      = op_e'(cmd_op);
          rop_d     = rop_e'(cmd_rop);
          x1_d      = cmd_x1;
          y1_d      = cmd_y1;
          x2_d      = cmd_x2;
          y2_d      = cmd_y2;
          w_d       = cmd_w;
          h_d       = cmd_h;
          fill_d    = cmd_fill_value;
          wr_byte_d = cmd_wr_byte;
          rev_d     = cmd_rev;
          cx_d      = cmd_rev ? (cmd_w - XW'(1)) : '0;
          cy_d      = cmd_rev ? (cmd_h - YW'(1)) : '0;
          bi_d      = '0;
          if (cmd_bad) begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            error_d = 1'b0;
            case (op_e'(cmd_op))
              OP_FILL:    state_d = (rop_e'(cmd_rop) == ROP_COPY) ? S_WR : S_RD_DST;
              OP_BLIT:    state_d = S_RD_SRC;
              OP_RD_BYTE: state_d = S_BYTE_RD;
              default:    state_d = S_BYTE_WR;
            endcase
          end
        end
      end

      S_RD_SRC: begin
        mem_x     = src_x;
        mem_y     = src_y;
        mem_rd_en = 1'b1;
        state_d   = (rop_q == ROP_COPY) ? S_WR : S_RD_DST;
      end

      S_RD_DST: begin
        mem_x     = dst_x;
        mem_y     = dst_y;
        mem_rd_en = 1'b1;
        // For BLIT the source pixel read last cycle is on mem_rd_data now.
        if (op_q == OP_BLIT) src_d = mem_rd_data;
        state_d   = S_WR;
      end

      S_WR: begin
        mem_x     = dst_x;
        mem_y     = dst_y;
        mem_wr_en = 1'b1;
        if (op_q == OP_FILL)
          mem_wr_data = rop_f(rop_q, fill_q, mem_rd_data);
        else if (rop_q == ROP_COPY)
          mem_wr_data = mem_rd_data;
        else
          mem_wr_data = rop_f(rop_q, src_q, mem_rd_data);

        if (last_px) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          if (rev_q) begin
            if (cx_q == '0) begin
              cx_d = w_q - XW'(1);
              cy_d = cy_q - YW'(1);
            end else begin
              cx_d = cx_q - XW'(1);
            end
          end else begin
            if (cx_q == w_q - XW'(1)) begin
              cx_d = '0;
              cy_d = cy_q + YW'(1);
            end else begin
              cx_d = cx_q + XW'(1);
            end
          end
          if (op_q == OP_FILL)
            state_d = (rop_q == ROP_COPY) ? S_WR : S_RD_DST;
          else
            state_d = S_RD_SRC;
        end
      end

      S_BYTE_RD: begin
        mem_x     = byte_x;
        mem_y     = y1_q;
        mem_rd_en = 1'b1;
        // Pixel i arrives one cycle after its read; shift in from the top so
        // bit 0 ends at the LSB after BYTE_BITS captures.
        if (bi_q != '0) shift_d = {mem_rd_data, shift_q[BYTE_BITS-1:1]};
        if (bi_q == BI_LAST) state_d = S_BYTE_LAST;
        else                 bi_d    = bi_q + BIW'(1);
      end

      S_BYTE_LAST: begin
        rd_byte_d       = {mem_rd_data, shift_q[BYTE_BITS-1:1]};
        rd_byte_valid_d = 1'b1;
        done_d          = 1'b1;
        state_d         = S_IDLE;
      end

      S_BYTE_WR: begin
        mem_x       = byte_x;
        mem_y       = y1_q;
        mem_wr_en   = 1'b1;
        mem_wr_data = wr_byte_q[bi_q];
        if (bi_q == BI_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          bi_d = bi_q + BIW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      op_q            <= OP_FILL;
      rop_q           <= ROP_COPY;
      x1_q            <= '0;
      y1_q            <= '0;
      x2_q            <= '0;
      y2_q            <= '0;
      w_q             <= '0;
      h_q             <= '0;
      fill_q          <= 1'b0;
      wr_byte_q       <= '0;
      rev_q           <= 1'b0;
      cx_q            <= '0;
      cy_q            <= '0;
      bi_q            <= '0;
      src_q           <= 1'b0;
      shift_q         <= '0;
      rd_byte_q       <= '0;
      rd_byte_valid_q <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q         <= state_d;
      op_q            <= op_d;
      rop_q           <= rop_d;
      x1_q            <= x1_d;
      y1_q            <= y1_d;
      x2_q            <= x2_d;
      y2_q            <= y2_d;
      w_q             <= w_d;
      h_q             <= h_d;
      fill_q          <= fill_d;
      wr_byte_q       <= wr_byte_d;
      rev_q           <= rev_d;
      cx_q            <= cx_d;
      cy_q            <= cy_d;
      bi_q            <= bi_d;
      src_q           <= src_d;
      shift_q         <= shift_d;
      rd_byte_q       <= rd_byte_d;
      rd_byte_valid_q <= rd_byte_valid_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = ~cmd_ready;
  assign done          = done_q;
  assign error         = error_q;
  assign rd_byte       = rd_byte_q;
  assign rd_byte_valid = rd_byte_valid_q;

endmodule

// File: tb/tb_gpu_rect_engine.sv
// Testbench for gpu_rect_engine: behavioural latency-1 pixel RAM, a table of
// directed commands with hand-computed completion timing/strobe counts, and
// hand-written sequences for RMW, overlapping blits, byte I/O and reset.
module tb_gpu_rect_engine;

  localparam int WIDTH  = 320;
  localparam int HEIGHT = 200;
  localparam int XW     = 9;
  localparam int YW     = 8;
  localparam int BB     = 8;
  localparam int LIMIT  = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op, cmd_rop;
  logic [XW-1:0] cmd_x1, cmd_x2, cmd_w;
  logic [YW-1:0] cmd_y1, cmd_y2, cmd_h;
  logic          cmd_fill_value;
  logic [BB-1:0] cmd_wr_byte;
  logic [XW-1:0] mem_x;
  logic [YW-1:0] mem_y;
  logic          mem_rd_en, mem_rd_data, mem_wr_en, mem_wr_data;
  logic          busy, done, error;
  logic [BB-1:0] rd_byte;
  logic          rd_byte_valid;

  gpu_rect_engine #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .BYTE_BITS(BB)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rop(cmd_rop),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_x2(cmd_x2), .cmd_y2(cmd_y2),
    .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_fill_value(cmd_fill_value), .cmd_wr_byte(cmd_wr_byte),
    .mem_x(mem_x), .mem_y(mem_y),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .error(error),
    .rd_byte(rd_byte), .rd_byte_valid(rd_byte_valid)
  );

  always #5 clk = ~clk;

  // Pixel RAM model: read data appears the cycle after the strobe.
  logic fb [HEIGHT][WIDTH];
  logic rd_q;
  assign mem_rd_data = rd_q;

  always @(posedge clk) begin
    if (mem_rd_en)
      rd_q <= (int'(mem_x) < WIDTH && int'(mem_y) < HEIGHT) ? fb[mem_y][mem_x] : 1'b0;
    if (mem_wr_en && int'(mem_x) < WIDTH && int'(mem_y) < HEIGHT)
      fb[mem_y][mem_x] <= mem_wr_data;
  end

  int both_cnt = 0;
  always @(negedge clk) if (mem_rd_en && mem_wr_en) both_cnt++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    op, rop, x1, y1, x2, y2, w, h;
    logic  fill;
    logic [BB-1:0] wb;
    logic  exp_err;
    int    exp_done, exp_rd, exp_wr;
    logic [BB-1:0] exp_rbyte;
  } vec_t;

  function automatic vec_t mk(string name, int op, int rop, int x1, int y1, int x2, int y2,
                              int w, int h, logic fill, logic [BB-1:0] wb, logic exp_err,
                              int exp_done, int exp_rd, int exp_wr, logic [BB-1:0] exp_rbyte);
    vec_t v;
    v.name = name; v.op = op; v.rop = rop; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
    v.w = w; v.h = h; v.fill = fill; v.wb = wb; v.exp_err = exp_err;
    v.exp_done = exp_done; v.exp_rd = exp_rd; v.exp_wr = exp_wr; v.exp_rbyte = exp_rbyte;
    return v;
  endfunction

  // Results of the most recent run().
  int   r_done, r_nrd, r_nwr;
  logic r_err1, r_errd, r_rbv;
  int   lx[$], ly[$], lc[$];
  logic ld[$];

  // Issue one command, then watch cycles 1.. until done (bounded).
  task automatic run(input vec_t v);
    @(negedge clk);
    cmd_op = 2'(v.op); cmd_rop = 2'(v.rop);
    cmd_x1 = XW'(v.x1); cmd_y1 = YW'(v.y1); cmd_x2 = XW'(v.x2); cmd_y2 = YW'(v.y2);
    cmd_w = XW'(v.w); cmd_h = YW'(v.h); cmd_fill_value = v.fill; cmd_wr_byte = v.wb;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    // Command fields are scrambled while busy; the engine must use its latched copy.
    cmd_valid = 1'b0; cmd_x1 = ~cmd_x1; cmd_y1 = ~cmd_y1; cmd_x2 = ~cmd_x2;
    cmd_fill_value = ~cmd_fill_value; cmd_wr_byte = ~cmd_wr_byte; cmd_rop = ~cmd_rop;
    r_done = 0; r_nrd = 0; r_nwr = 0; r_err1 = 1'bx; r_errd = 1'bx; r_rbv = 1'bx;
    lx.delete(); ly.delete(); lc.delete(); ld.delete();
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (k == 1) r_err1 = error;
      if (mem_rd_en) r_nrd++;
      if (mem_wr_en) begin
        r_nwr++;
        lx.push_back(int'(mem_x)); ly.push_back(int'(mem_y));
        lc.push_back(k); ld.push_back(mem_wr_data);
      end
      if (done) begin
        r_done = k; r_errd = error; r_rbv = rd_byte_valid;
        break;
      end
    end
  endtask

  vec_t vecs[12];
  vec_t v;

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_rop = '0; cmd_x1 = '0; cmd_y1 = '0;
    cmd_x2 = '0; cmd_y2 = '0; cmd_w = '0; cmd_h = '0; cmd_fill_value = 1'b0;
    cmd_wr_byte = '0;
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++) fb[y][x] = 1'b0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done_error", {done, error}, 0);
    check("rst_strobes", {mem_rd_en, mem_wr_en, mem_wr_data}, 0);
    check("rst_addr", {mem_x, mem_y}, 0);
    check("rst_rd_byte", {rd_byte, rd_byte_valid}, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---------------- table-driven commands ----------------
    //                 name            op rop  x1   y1   x2  y2  w  h fill wb     err done rd wr rbyte
    vecs[0]  = mk("fill_copy",       0, 0,   5,   7,   0,  0, 3, 2, 1, 8'h00, 0,  7,  0, 6, 8'h00);
    vecs[1]  = mk("fill_x_ovf",      0, 0, 318,   0,   0,  0, 3, 1, 1, 8'h00, 1,  1,  0, 0, 8'h00);
    vecs[2]  = mk("fill_y_edge",     0, 0,   0, 199,   0,  0, 2, 1, 1, 8'h00, 0,  3,  0, 2, 8'h00);
    vecs[3]  = mk("fill_w0",         0, 0,  10,  10,   0,  0, 0, 1, 1, 8'h00, 1,  1,  0, 0, 8'h00);
    vecs[4]  = mk("blit_dst_ovf",    1, 0,   0,   0, 318,  0, 4, 1, 0, 8'h00, 1,  1,  0, 0, 8'h00);
    vecs[5]  = mk("rdbyte_y_ovf",    2, 0,   0, 200,   0,  0, 0, 0, 0, 8'h00, 1,  1,  0, 0, 8'h00);
    vecs[6]  = mk("wrbyte_x_ovf",    3, 0, 313,   0,   0,  0, 0, 0, 0, 8'h00, 1,  1,  0, 0, 8'h00);
    vecs[7]  = mk("fill_h0",         0, 2,  20,  20,   0,  0, 4, 0, 1, 8'h00, 1,  1,  0, 0, 8'h00);
    vecs[8]  = mk("fill_or_2x2",     0, 2, 100, 100,   0,  0, 2, 2, 1, 8'h00, 0,  9,  4, 4, 8'h00);
    vecs[9]  = mk("blit_copy_rev",   1, 0, 200,  50, 200, 60, 3, 2, 0, 8'h00, 0, 13,  6, 6, 8'h00);
    vecs[10] = mk("wrbyte_ok",       3, 3,   0,   0,   0,  0, 0, 0, 0, 8'h3C, 0,  9,  0, 8, 8'h00);
    vecs[11] = mk("rdbyte_ok",       2, 0,   0,   0,   0,  0, 0, 0, 0, 8'h00, 0, 10,  8, 0, 8'h3C);

    for (int i = 0; i < 12; i++) begin
      run(vecs[i]);
      check({vecs[i].name, "_done_cycle"}, r_done, vecs[i].exp_done);
      check({vecs[i].name, "_error_c1"}, r_err1, vecs[i].exp_err);
      check({vecs[i].name, "_error_done"}, r_errd, vecs[i].exp_err);
      check({vecs[i].name, "_strobes"}, {r_nrd[15:0], r_nwr[15:0]},
            {vecs[i].exp_rd[15:0], vecs[i].exp_wr[15:0]});
      check({vecs[i].name, "_rbv"}, r_rbv, (vecs[i].op == 2) && !vecs[i].exp_err);
      if (vecs[i].op == 2 && !vecs[i].exp_err)
        check({vecs[i].name, "_rd_byte"}, rd_byte, vecs[i].exp_rbyte);
    end
    check("fill_or_pixel", fb[101][101], 1);
    check("fill_y_edge_pixel", {fb[199][0], fb[199][1], fb[199][2]}, 3'b110);

    // ---------------- FILL COPY address/timing sequence ----------------
    run(vecs[0]);
    check("seqA_wr_count", lx.size(), 6);
    for (int k = 0; k < 6 && k < lx.size(); k++)
      check($sformatf("seqA_wr%0d", k), {16'(lx[k]), 16'(ly[k]), 16'(lc[k]), 15'd0, ld[k]},
            {16'(5 + k % 3), 16'(7 + k / 3), 16'(k + 1), 15'd0, 1'b1});

    // ---------------- FILL XOR read-modify-write ----------------
    fb[0][0] = 1; fb[0][1] = 0; fb[0][2] = 1; fb[0][3] = 0;
    v = mk("fill_xor", 0, 3, 0, 0, 0, 0, 4, 1, 1, 8'h00, 0, 9, 4, 4, 8'h00);
    run(v);
    check("seqB_done", r_done, 9);
    check("seqB_pixels", {fb[0][0], fb[0][1], fb[0][2], fb[0][3]}, 4'b0101);
    check("seqB_wr_cycles", {8'(lc[0]), 8'(lc[1]), 8'(lc[2]), 8'(lc[3])}, {8'd2, 8'd4, 8'd6, 8'd8});

    // ---------------- overlapping BLIT to the right (reverse) ----------------
    fb[0][0] = 1; fb[0][1] = 0; fb[0][2] = 1; fb[0][3] = 1; fb[0][4] = 0;
    v = mk("blit_ovl", 1, 0, 0, 0, 1, 0, 4, 1, 0, 8'h00, 0, 9, 4, 4, 8'h00);
    run(v);
    check("seqC_done", r_done, 9);
    check("seqC_order", {8'(lx[0]), 8'(lx[1]), 8'(lx[2]), 8'(lx[3])}, {8'd4, 8'd3, 8'd2, 8'd1});
    check("seqC_pixels", {fb[0][1], fb[0][2], fb[0][3], fb[0][4]}, 4'b1011);

    // ---------------- overlapping BLIT to the left (forward) ----------------
    fb[5][0] = 0; fb[5][1] = 0; fb[5][2] = 1; fb[5][3] = 1; fb[5][4] = 0; fb[5][5] = 1;
    v = mk("blit_fwd", 1, 0, 2, 5, 0, 5, 4, 1, 0, 8'h00, 0, 9, 4, 4, 8'h00);
    run(v);
    check("seqC2_order", {8'(lx[0]), 8'(lx[3])}, {8'd0, 8'd3});
    check("seqC2_pixels", {fb[5][0], fb[5][1], fb[5][2], fb[5][3]}, 4'b1101);

    // ---------------- BLIT XOR (3 cycles per pixel) ----------------
    fb[10][10] = 1; fb[10][11] = 1; fb[11][10] = 0; fb[11][11] = 1;
    v = mk("blit_xor", 1, 3, 10, 10, 10, 11, 2, 1, 0, 8'h00, 0, 7, 4, 2, 8'h00);
    run(v);
    check("seqD_done", r_done, 7);
    check("seqD_strobes", {r_nrd[7:0], r_nwr[7:0]}, {8'd4, 8'd2});
    check("seqD_pixels", {fb[11][10], fb[11][11]}, 2'b10);

    // ---------------- WRITE_BYTE then READ_BYTE at the far corner ----------------
    v = mk("wr_corner", 3, 0, 312, 199, 0, 0, 0, 0, 0, 8'hA5, 0, 9, 0, 8, 8'h00);
    run(v);
    check("seqE_wr_done", r_done, 9);
    check("seqE_wr_pixels", {fb[199][319], fb[199][318], fb[199][317], fb[199][316],
                             fb[199][315], fb[199][314], fb[199][313], fb[199][312]}, 8'hA5);
    v = mk("rd_corner", 2, 0, 312, 199, 0, 0, 0, 0, 0, 8'h00, 0, 10, 8, 0, 8'hA5);
    run(v);
    check("seqE_rd_done", r_done, 10);
    check("seqE_rd_byte", {rd_byte, r_rbv}, {8'hA5, 1'b1});
    @(negedge clk);
    check("seqE_rbv_pulse", {rd_byte_valid, done}, 2'b00);
    check("seqE_rd_byte_hold", rd_byte, 8'hA5);

    // ---------------- error then clear ----------------
    v = mk("err_fill", 0, 0, 318, 0, 0, 0, 3, 1, 1, 8'h00, 1, 1, 0, 0, 8'h00);
    run(v);
    check("seqF_err", {r_errd, 8'(r_done), 8'(r_nrd + r_nwr)}, {1'b1, 8'd1, 8'd0});
    @(negedge clk);
    check("seqF_err_held", error, 1);
    run(vecs[2]);
    check("seqF_err_cleared", r_err1, 0);

    // ---------------- asynchronous reset mid-BLIT ----------------
    @(negedge clk);
    cmd_op = 2'd1; cmd_rop = 2'd0; cmd_x1 = 9'd0; cmd_y1 = 8'd20; cmd_x2 = 9'd0;
    cmd_y2 = 8'd21; cmd_w = 9'd20; cmd_h = 8'd5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("seqG_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("seqG_rst_ready", {cmd_ready, busy}, 2'b10);
    check("seqG_rst_outs", {mem_rd_en, mem_wr_en, mem_wr_data, done, error, rd_byte_valid}, 0);
    check("seqG_rst_addr_byte", {mem_x, mem_y, rd_byte}, 0);
    @(negedge clk);
    rst = 1'b0;
    v = mk("post_rst_fill", 0, 0, 50, 50, 0, 0, 2, 1, 1, 8'h00, 0, 3, 0, 2, 8'h00);
    run(v);
    check("seqG_post_fill", {8'(r_done), r_errd, fb[50][50], fb[50][51]}, {8'd3, 1'b0, 1'b1, 1'b1});

    check("no_rd_wr_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
